// File: rtl/io_switch_debounce.sv
// io_switch_debounce
//   Input stage for the board switches, placed upstream of the memory/IO mux.
//   The 16 data switches and 3 control switches are first synchronised to
//   sys_clk through two flops. The combined 19-bit vector is then debounced
//   as one unit. The block keeps the debounced values and a sticky change mask
//   for the data switches. The CPU reads these back as IO registers through a
//   combinational read mux.
//
// Ports
//   sys_clk      in   1   system clock, all state on rising edge
//   sys_rst_n    in   1   asynchronous, active-low reset
//   sw_raw       in   16  raw data switches (asynchronous)
//   ctl_raw      in   3   raw control switches (asynchronous)
//   ioread       in   1   IO read strobe
//   switchctrl   in   1   switch chip-select
//   addr_sel     in   2   0=data, 1=control, 2=change mask (read-clear), 3=reserved
//   ioread_data  out  16  read data, valid while ioread & switchctrl, else 0
//   sw_stable    out  16  debounced data switches
//   ctl_stable   out  3   debounced control switches
//   sw_changed   out  1   change mask is non-zero
//   sw_irq       out  1   one-cycle pulse after a commit that changed a data switch
//
// Configuration
//   SW_EDGE_IRQ_EN : when defined, builds the registered commit pulse on sw_irq.
//                    When undefined, sw_irq is tied low.

module io_switch_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [15:0] sw_raw,
  input  logic [2:0]  ctl_raw,
  input  logic        ioread,
  input  logic        switchctrl,
  input  logic [1:0]  addr_sel,
  output logic [15:0] ioread_data,
  output logic [15:0] sw_stable,
  output logic [2:0]  ctl_stable,
  output logic        sw_changed,
  output logic        sw_irq
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  state_t      state, state_nxt;
  logic [18:0] sync1, sync2;
  logic [18:0] cand, cand_nxt;
  logic [18:0] stable;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic        commit;
  logic [15:0] commit_diff;
  logic [15:0] mask, mask_nxt;
  logic        read_en;
  logic        mask_clr;

  // Two-flop synchroniser for the asynchronous switch inputs
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {ctl_raw, sw_raw};
      sync2 <= sync1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // Debounce FSM. Any deviation from the candidate either drops back to IDLE
  // (the input returned to the stable value) or restarts the count on the new
  // value.
  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (sync2 != stable) begin
          cand_nxt  = sync2;
          cnt_nxt   = '0;
          state_nxt = COUNT;
        end
      end
      COUNT: begin
        if (sync2 != cand) begin
          if (sync2 == stable) begin
            state_nxt = IDLE;
          end else begin
            cand_nxt = sync2;
            cnt_nxt  = '0;
          end
        end else if (cnt == CNT_LAST) begin
          commit    = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Only the data-switch part of a commit feeds the change mask.
  assign commit_diff = commit ? (stable[15:0] ^ cand[15:0]) : 16'h0000;

  assign read_en  = ioread & switchctrl;
  assign mask_clr = read_en & (addr_sel == 2'd2);

  // A read-clear and a commit on the same edge: the old bits are dropped and
  // the bits from this commit are kept.
  assign mask_nxt = mask_clr ? commit_diff : (mask | commit_diff);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cand   <= '0;
      cnt    <= '0;
      stable <= '0;
      mask   <= '0;
    end else begin
      cand <= cand_nxt;
      cnt  <= cnt_nxt;
      if (commit) stable <= cand;
      mask <= mask_nxt;
    end
  end

`ifdef SW_EDGE_IRQ_EN
  logic irq_r;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) irq_r <= 1'b0;
    else            irq_r <= (commit_diff != 16'h0000);
  end

  assign sw_irq = irq_r;
`else
  assign sw_irq = 1'b0;
`endif

  assign sw_stable  = stable[15:0];
  assign ctl_stable = stable[18:16];
  assign sw_changed = |mask;

  always_comb begin
    ioread_data = 16'h0000;
    if (read_en) begin
      case (addr_sel)
        2'd0:    ioread_data = stable[15:0];
        2'd1:    ioread_data = {13'b0, stable[18:16]};
        2'd2:    ioread_data = mask;
        default: ioread_data = 16'h0000;
      endcase
    end
  end

endmodule

// File: tb/tb_io_switch_debounce.sv
`timescale 1ns/1ps

module tb_io_switch_debounce;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] sw_raw;
  logic [2:0]  ctl_raw;
  logic        ioread;
  logic        switchctrl;
  logic [1:0]  addr_sel;
  logic [15:0] ioread_data;
  logic [15:0] sw_stable;
  logic [2:0]  ctl_stable;
  logic        sw_changed;
  logic        sw_irq;

  int errors = 0;
  int checks = 0;
  int irq_hi = 0;

  io_switch_debounce #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(20)
  ) dut (
    .sys_clk    (clk),
    .sys_rst_n  (rst_n),
    .sw_raw     (sw_raw),
    .ctl_raw    (ctl_raw),
    .ioread     (ioread),
    .switchctrl (switchctrl),
    .addr_sel   (addr_sel),
    .ioread_data(ioread_data),
    .sw_stable  (sw_stable),
    .ctl_stable (ctl_stable),
    .sw_changed (sw_changed),
    .sw_irq     (sw_irq)
  );

  always #10 clk = ~clk;

  // Number of clock cycles in which sw_irq was high.
  always @(negedge clk) if (sw_irq) irq_hi++;

  typedef struct {
    logic        rd;
    logic        cs;
    logic [1:0]  addr;
    logic [15:0] exp;
  } rd_vec_t;

  rd_vec_t vec [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_irq;
    int   exp_irq_total;
`ifdef SW_EDGE_IRQ_EN
    exp_irq = 1'b1;
    exp_irq_total = 4;
`else
    exp_irq = 1'b0;
    exp_irq_total = 0;
`endif

    // read-mux vectors, applied while sw_stable=A5A5, ctl=0, mask=A5A5
    vec[0] = '{1'b1, 1'b1, 2'd0, 16'hA5A5};
    vec[1] = '{1'b1, 1'b1, 2'd1, 16'h0000};
    vec[2] = '{1'b1, 1'b1, 2'd2, 16'hA5A5};
    vec[3] = '{1'b1, 1'b1, 2'd3, 16'h0000};
    vec[4] = '{1'b0, 1'b1, 2'd0, 16'h0000};
    vec[5] = '{1'b1, 1'b0, 2'd0, 16'h0000};
    vec[6] = '{1'b1, 1'b0, 2'd2, 16'h0000};
    vec[7] = '{1'b0, 1'b0, 2'd2, 16'h0000};

    // Test 1: A5A5 held through reset
    rst_n = 1'b0; sw_raw = 16'hA5A5; ctl_raw = 3'b000;
    ioread = 1'b1; switchctrl = 1'b1; addr_sel = 2'd0;
    tick(3);
    chk("rst_sw_stable", sw_stable, 16'h0);
    chk("rst_ctl_stable", ctl_stable, 3'h0);
    chk("rst_ioread_data", ioread_data, 16'h0);
    chk("rst_sw_changed", sw_changed, 1'b0);
    chk("rst_sw_irq", sw_irq, 1'b0);
    ioread = 1'b0; switchctrl = 1'b0;
    rst_n = 1'b1;
    tick(6);
    chk("t1_before_commit", sw_stable, 16'h0);
    tick(1);
    chk("t1_commit", sw_stable, 16'hA5A5);
    chk("t1_changed", sw_changed, 1'b1);
    chk("t1_irq", sw_irq, exp_irq);

    for (int i = 0; i < 8; i++) begin
      ioread = vec[i].rd; switchctrl = vec[i].cs; addr_sel = vec[i].addr;
      #1;
      chk($sformatf("rdvec%0d", i), ioread_data, vec[i].exp);
    end
    ioread = 1'b0; switchctrl = 1'b0; addr_sel = 2'd0;
    tick(1);
    chk("t1_irq_one_cycle", sw_irq, 1'b0);

    // Test 3: read-clear of the mask
    ioread = 1'b1; switchctrl = 1'b1; addr_sel = 2'd2;
    #1;
    chk("t3_read_mask", ioread_data, 16'hA5A5);
    tick(1);
    ioread = 1'b0;
    #1;
    chk("t3_changed_cleared", sw_changed, 1'b0);
    ioread = 1'b1;
    #1;
    chk("t3_mask_zero", ioread_data, 16'h0);
    ioread = 1'b0; switchctrl = 1'b0;

    // Test 2: 3-cycle glitch on bit0 from stable 0
    rst_n = 1'b0; sw_raw = 16'h0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    sw_raw = 16'h0001;
    tick(3);
    sw_raw = 16'h0000;
    tick(10);
    chk("t2_glitch_stable", sw_stable, 16'h0);
    chk("t2_glitch_mask", sw_changed, 1'b0);

    // Test 4: read-clear on the same edge as a commit
    sw_raw = 16'h8000;
    tick(7);
    chk("t4_first_commit", sw_stable, 16'h8000);
    sw_raw = 16'h8001;
    tick(6);
    chk("t4_pre_commit", sw_stable, 16'h8000);
    ioread = 1'b1; switchctrl = 1'b1; addr_sel = 2'd2;
    #1;
    chk("t4_read_old_mask", ioread_data, 16'h8000);
    tick(1);
    ioread = 1'b0;
    #1;
    chk("t4_commit", sw_stable, 16'h8001);
    chk("t4_irq", sw_irq, exp_irq);
    chk("t4_changed", sw_changed, 1'b1);
    ioread = 1'b1;
    #1;
    chk("t4_new_mask", ioread_data, 16'h0001);
    ioread = 1'b0; switchctrl = 1'b0;

    // Test 5: 0 -> 1 -> 2 with restart, single commit to 2
    rst_n = 1'b0; sw_raw = 16'h0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    sw_raw = 16'h0001;
    tick(2);
    sw_raw = 16'h0002;
    tick(6);
    chk("t5_pre_commit", sw_stable, 16'h0);
    tick(1);
    chk("t5_commit", sw_stable, 16'h0002);
    ioread = 1'b1; switchctrl = 1'b1; addr_sel = 2'd2;
    #1;
    chk("t5_mask", ioread_data, 16'h0002);
    ioread = 1'b0; switchctrl = 1'b0;

    // Reset in the middle of a count
    sw_raw = 16'h0004;
    tick(4);
    rst_n = 1'b0; sw_raw = 16'h0;
    #1;
    chk("t5_async_rst", sw_stable, 16'h0);
    tick(1);
    rst_n = 1'b1;
    tick(10);
    chk("t5_abort_stable", sw_stable, 16'h0);
    chk("t5_abort_changed", sw_changed, 1'b0);

    // Test 6: control switches
    ctl_raw = 3'b101;
    tick(7);
    chk("t6_ctl_stable", ctl_stable, 3'h5);
    chk("t6_sw_stable", sw_stable, 16'h0);
    chk("t6_changed", sw_changed, 1'b0);
    ioread = 1'b1; switchctrl = 1'b1; addr_sel = 2'd1;
    #1;
    chk("t6_read_ctl", ioread_data, 16'h0005);
    addr_sel = 2'd2;
    #1;
    chk("t6_mask_unchanged", ioread_data, 16'h0);
    ioread = 1'b0; switchctrl = 1'b0;
    tick(2);

    chk("irq_cycles_total", irq_hi, exp_irq_total);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
